adder_unit: RTL and testbench
=============================

Name: adder_unit

Overview:
Registered, pipelined two-operand unsigned/two's-complement adder for the datapath. Default width is 12 bits. Adds op_a and op_b modulo 2^WIDTH, and flags carry-out and signed overflow. Accepts one operation per clock with a valid qualifier; there is no backpressure. Results appear after a fixed latency of STAGES cycles.

Parameters:
WIDTH, 12, operand and result width in bits (legal range 2..64).
STAGES, 1, pipeline depth. Legal values are 1 or 2. With 2, the low half is added in stage 1 and the high half in stage 2 (carry-split pipeline).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  qualifies op_a/op_b this cycle.
op_a  input  WIDTH  operand A.
op_b  input  WIDTH  operand B.
out_valid  output  1  op_c/carry_out/overflow hold a new result this cycle.
op_c  output  WIDTH  sum (op_a + op_b) mod 2^WIDTH.
carry_out  output  1  unsigned carry out of the MSB.
overflow  output  1  signed overflow: operands share a sign bit and the result sign differs.

Behaviour:
- Reset: asserting rst clears out_valid, op_c, carry_out, overflow and all internal pipeline registers to 0 immediately, with no clock needed. Deassertion is synchronous to clk by system convention.
- Latency: a valid input at edge N yields out_valid=1 with its result at edge N+STAGES.
- Throughput: one operation per cycle. Back-to-back valids produce back-to-back outputs in order.
- Valid pipeline: the valid bit shifts every cycle regardless of data. out_valid is 1 only for cycles carrying a real result.
- Data registers load only on a valid stage. With in_valid=0, outputs keep the last result and out_valid=0.
- Arithmetic: full sum is WIDTH+1 bits. op_c gets the low WIDTH bits (wrap-around), carry_out gets bit WIDTH. overflow = (a_msb == b_msb) && (c_msb != a_msb).
- STAGES=2 split, with L = WIDTH/2 (floor):
  - Stage 1 registers the low L bits of the sum, the low carry, and the upper operand bits.
  - Stage 2 adds the upper bits plus the registered low carry, then concatenates the result.
  - The result must be bit-identical to STAGES=1.
- Reset mid-operation: every in-flight operation is discarded. No out_valid pulse follows for inputs accepted before reset.
- Inputs are ignored while rst=1.
- Illegal STAGES: elaboration-time error or assertion.

Decomposition:
- Shared package: ADDER_DEFAULT_WIDTH = 12, legal STAGES constants, and a result struct/type grouping {sum, carry, overflow} for reuse by consumers.
- One sub-module, adder_slice: a combinational WIDTH-parameterised ripple add with carry-in. It returns sum and carry-out, plus the operand/result MSBs needed for the overflow check.
- adder_unit instantiates one slice for STAGES=1, or two slices (low/high) for STAGES=2.

Test Plan:
- Reset then zeros: rst pulse, then in_valid=1, op_a=0x000, op_b=0x000 -> after STAGES cycles, out_valid=1, op_c=0x000, carry_out=0, overflow=0. During rst, all outputs are 0 asynchronously.
- Simple add: 0x005 + 0x003 -> op_c=0x008, carry_out=0, overflow=0.
- Unsigned wrap: 0xFFF + 0x001 -> op_c=0x000, carry_out=1, overflow=0. Also 0x800 + 0x800 -> op_c=0x000, carry_out=1, overflow=1.
- Signed overflow: 0x7FF + 0x001 -> op_c=0x800, carry_out=0, overflow=1.
- Streaming ramp: op_a increments each cycle from 0x000, op_b lags op_a by one (matching a ramp stimulus style), 40 consecutive valid cycles -> 40 consecutive out_valid pulses with op_c=op_a+op_b mod 0x1000, in order. Repeat with STAGES=2 and confirm identical results.
- Reset mid-stream: assert rst asynchronously between edges while 2 operations are in flight -> outputs go to 0 at once, and no out_valid for those operations after release. Check that a gap cycle (in_valid=0) keeps op_c at its last value with out_valid=0.

Source files
------------

// File: rtl/adder_unit_pkg.sv
// Shared constants, result type and overflow helper for the pipelined adder.
// Consumers import this package to size datapaths and unpack results.
package adder_unit_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 12;
  localparam int STAGES_SINGLE       = 1;
  localparam int STAGES_SPLIT        = 2;

  typedef struct packed {
    logic [ADDER_DEFAULT_WIDTH-1:0] sum;
    logic                           carry;
    logic                           overflow;
  } adder_result_t;

  function automatic logic stages_legal(input int stages);
    return (stages == STAGES_SINGLE) || (stages == STAGES_SPLIT);
  endfunction

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_unit_slice.sv
// Combinational W-bit add with carry-in; exposes sum, carry-out and the
// operand/result sign bits so the caller can derive signed overflow.
module adder_slice #(
  parameter int W = 6
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_a_msb,
  output logic         o_b_msb,
  output logic         o_sum_msb
);

  logic [W:0] w_full;

  assign w_full    = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  assign o_sum     = w_full[W-1:0];
  assign o_cout    = w_full[W];
  assign o_a_msb   = i_a[W-1];
  assign o_b_msb   = i_b[W-1];
  assign o_sum_msb = w_full[W-1];

endmodule

// File: rtl/adder_unit.sv
// Pipelined two-operand adder with carry-out and signed overflow flags.
// STAGES=1 adds in one cycle; STAGES=2 splits the carry chain across two.
module adder_unit
  import adder_unit_pkg::*;
#(
  parameter int WIDTH  = ADDER_DEFAULT_WIDTH,
  parameter int STAGES = STAGES_SINGLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] op_c,
  output logic             carry_out,
  output logic             overflow
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_op_c;
  logic             r_carry;
  logic             r_ovf;

  assign out_valid = r_out_valid;
  assign op_c      = r_op_c;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("adder_unit: WIDTH must be in 2..64");
  end

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("adder_unit: STAGES must be 1 or 2");
  end else if (STAGES == STAGES_SINGLE) begin : g_single
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_a_msb;
    logic             w_b_msb;
    logic             w_s_msb;

    adder_slice #(.W(WIDTH)) u_slice (
      .i_a       (op_a),
      .i_b       (op_b),
      .i_cin     (1'b0),
      .o_sum     (w_sum),
      .o_cout    (w_cout),
      .o_a_msb   (w_a_msb),
      .o_b_msb   (w_b_msb),
      .o_sum_msb (w_s_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out_valid <= 1'b0;
        r_op_c      <= '0;
        r_carry     <= 1'b0;
        r_ovf       <= 1'b0;
      end else begin
        r_out_valid <= in_valid;
        if (in_valid) begin
          r_op_c  <= w_sum;
          r_carry <= w_cout;
          r_ovf   <= ovf_flag(w_a_msb, w_b_msb, w_s_msb);
        end
      end
    end
  end else begin : g_split
    localparam int L = WIDTH / 2;
    localparam int H = WIDTH - L;

    logic         r_s1_valid;
    logic [L-1:0] r_lo_sum;
    logic         r_lo_carry;
    logic [H-1:0] r_hi_a;
    logic [H-1:0] r_hi_b;

    logic [L-1:0] w_lo_sum;
    logic         w_lo_cout;
    logic [2:0]   w_lo_msbs_unused;
    logic [H-1:0] w_hi_sum;
    logic         w_hi_cout;
    logic         w_a_msb;
    logic         w_b_msb;
    logic         w_s_msb;

    adder_slice #(.W(L)) u_lo (
      .i_a       (op_a[L-1:0]),
      .i_b       (op_b[L-1:0]),
      .i_cin     (1'b0),
      .o_sum     (w_lo_sum),
      .o_cout    (w_lo_cout),
      .o_a_msb   (w_lo_msbs_unused[0]),
      .o_b_msb   (w_lo_msbs_unused[1]),
      .o_sum_msb (w_lo_msbs_unused[2])
    );

    // Upper half finishes the add one cycle later using the registered low carry.
    adder_slice #(.W(H)) u_hi (
      .i_a       (r_hi_a),
      .i_b       (r_hi_b),
      .i_cin     (r_lo_carry),
      .o_sum     (w_hi_sum),
      .o_cout    (w_hi_cout),
      .o_a_msb   (w_a_msb),
      .o_b_msb   (w_b_msb),
      .o_sum_msb (w_s_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1_valid  <= 1'b0;
        r_lo_sum    <= '0;
        r_lo_carry  <= 1'b0;
        r_hi_a      <= '0;
        r_hi_b      <= '0;
        r_out_valid <= 1'b0;
        r_op_c      <= '0;
        r_carry     <= 1'b0;
        r_ovf       <= 1'b0;
      end else begin
        r_s1_valid  <= in_valid;
        r_out_valid <= r_s1_valid;
        if (in_valid) begin
          r_lo_sum   <= w_lo_sum;
          r_lo_carry <= w_lo_cout;
          r_hi_a     <= op_a[WIDTH-1:L];
          r_hi_b     <= op_b[WIDTH-1:L];
        end
        if (r_s1_valid) begin
          r_op_c  <= {w_hi_sum, r_lo_sum};
          r_carry <= w_hi_cout;
          r_ovf   <= ovf_flag(w_a_msb, w_b_msb, w_s_msb);
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_unit.sv
// Drives identical stimulus into a 1-stage and a 2-stage adder_unit and
// compares both against an integer-arithmetic reference with per-depth delay.
module tb_adder_unit;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;

  logic         o1_valid, o1_carry, o1_ovf;
  logic [W-1:0] o1_c;
  logic         o2_valid, o2_carry, o2_ovf;
  logic [W-1:0] o2_c;

  int n_checks = 0;
  int n_pass   = 0;

  // Inputs accepted 1 and 2 edges ago, plus the last result each depth should hold.
  logic         h_v [1:2];
  logic [W-1:0] h_a [1:2];
  logic [W-1:0] h_b [1:2];
  logic [W-1:0] ex_c  [1:2];
  logic         ex_co [1:2];
  logic         ex_ov [1:2];

  always #5 clk = ~clk;

  adder_unit #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op_a(op_a), .op_b(op_b),
    .out_valid(o1_valid), .op_c(o1_c), .carry_out(o1_carry), .overflow(o1_ovf)
  );

  adder_unit #(.WIDTH(W), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op_a(op_a), .op_b(op_b),
    .out_valid(o2_valid), .op_c(o2_c), .carry_out(o2_carry), .overflow(o2_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] c, output logic co, output logic ov);
    int full, sa, sb, ss;
    full = int'(a) + int'(b);
    c    = W'(full % 4096);
    co   = (full >= 4096);
    sa   = (a >= 2048) ? int'(a) - 4096 : int'(a);
    sb   = (b >= 2048) ? int'(b) - 4096 : int'(b);
    ss   = sa + sb;
    ov   = (ss > 2047) || (ss < -2048);
  endfunction

  task automatic model_clear();
    for (int s = 1; s <= 2; s++) begin
      h_v[s] = 1'b0; h_a[s] = '0; h_b[s] = '0;
      ex_c[s] = '0; ex_co[s] = 1'b0; ex_ov[s] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      model_clear();
    end else begin
      h_v[2] = h_v[1]; h_a[2] = h_a[1]; h_b[2] = h_b[1];
      h_v[1] = in_valid; h_a[1] = op_a; h_b[1] = op_b;
      for (int s = 1; s <= 2; s++)
        if (h_v[s]) ref_add(h_a[s], h_b[s], ex_c[s], ex_co[s], ex_ov[s]);
    end
  endtask

  task automatic check_outputs();
    chk("s1_valid", 32'(o1_valid), 32'(h_v[1]));
    chk("s1_op_c",  32'(o1_c),     32'(ex_c[1]));
    chk("s1_carry", 32'(o1_carry), 32'(ex_co[1]));
    chk("s1_ovf",   32'(o1_ovf),   32'(ex_ov[1]));
    chk("s2_valid", 32'(o2_valid), 32'(h_v[2]));
    chk("s2_op_c",  32'(o2_c),     32'(ex_c[2]));
    chk("s2_carry", 32'(o2_carry), 32'(ex_co[2]));
    chk("s2_ovf",   32'(o2_ovf),   32'(ex_ov[2]));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s1_valid"}, 32'(o1_valid), 32'd0);
    chk({tag, "_s1_op_c"},  32'(o1_c),     32'd0);
    chk({tag, "_s1_carry"}, 32'(o1_carry), 32'd0);
    chk({tag, "_s1_ovf"},   32'(o1_ovf),   32'd0);
    chk({tag, "_s2_valid"}, 32'(o2_valid), 32'd0);
    chk({tag, "_s2_op_c"},  32'(o2_c),     32'd0);
    chk({tag, "_s2_carry"}, 32'(o2_carry), 32'd0);
    chk({tag, "_s2_ovf"},   32'(o2_ovf),   32'd0);
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1 time unit later.
  task automatic do_cycle(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    rst = r; in_valid = v; op_a = a; op_b = b;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    $display("t=%0t rst=%0b in_v=%0b a=%03h b=%03h | s1 v=%0b c=%03h co=%0b ov=%0b | s2 v=%0b c=%03h co=%0b ov=%0b",
             $time, r, v, a, b, o1_valid, o1_c, o1_carry, o1_ovf, o2_valid, o2_c, o2_carry, o2_ovf);
  endtask

  initial begin
    model_clear();
    #1 rst = 1'b1;
    #1 check_all_zero("por");

    do_cycle(1'b1, 1'b1, 12'h123, 12'h456);
    do_cycle(1'b0, 1'b1, 12'h000, 12'h000);
    do_cycle(1'b0, 1'b1, 12'h005, 12'h003);
    do_cycle(1'b0, 1'b1, 12'hFFF, 12'h001);
    do_cycle(1'b0, 1'b1, 12'h800, 12'h800);
    do_cycle(1'b0, 1'b1, 12'h7FF, 12'h001);
    // Gap: out_valid drops, data holds the last result.
    do_cycle(1'b0, 1'b0, 12'hAAA, 12'h555);
    do_cycle(1'b0, 1'b0, 12'h111, 12'h222);
    do_cycle(1'b0, 1'b0, 12'h333, 12'h444);

    for (int i = 0; i < 40; i++)
      do_cycle(1'b0, 1'b1, W'(i), (i == 0) ? W'(0) : W'(i - 1));
    do_cycle(1'b0, 1'b0, 12'h000, 12'h000);
    do_cycle(1'b0, 1'b0, 12'h000, 12'h000);

    for (int i = 0; i < 120; i++)
      do_cycle(1'b0, ($urandom_range(0, 3) != 0), W'($urandom), W'($urandom));

    // Two operations in flight, then asynchronous reset between edges.
    do_cycle(1'b0, 1'b1, 12'h7F0, 12'h0A0);
    do_cycle(1'b0, 1'b1, 12'hC00, 12'hC00);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    model_clear();
    do_cycle(1'b1, 1'b1, 12'hFFF, 12'hFFF);
    for (int i = 0; i < 4; i++)
      do_cycle(1'b0, 1'b0, W'($urandom), W'($urandom));
    do_cycle(1'b0, 1'b1, 12'h0FF, 12'h001);
    for (int i = 0; i < 3; i++)
      do_cycle(1'b0, 1'b0, 12'h000, 12'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
